// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-port AXI read arbiter in front of the DDR3 controller.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // One-hot grant encodings, bit 0 = port s0, bit 1 = port s1.
  localparam logic [1:0] GntNone = 2'b00;
  localparam logic [1:0] GntS0   = 2'b01;
  localparam logic [1:0] GntS1   = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant selection; round-robin on ties, or port 0 always wins a tie when
// ARB_FIXED_PRIORITY_EN is defined.
module rr_arbiter2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] gnt_o
);

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = ^last_i;
`endif

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
`ifdef ARB_FIXED_PRIORITY_EN
      gnt_o = GntS0;
`else
      // The port that was not served last takes the tie.
      gnt_o = last_i[0] ? GntS1 : GntS0;
`endif
    end
  end

endmodule

// File: rtl/axi_ddr3_rd_arbiter.sv
// Arbitrates two AXI read requesters onto one DDR3 controller read port, one burst at a time.
// Tie-break policy is selected by ARB_FIXED_PRIORITY_EN (see rr_arbiter2).
module axi_ddr3_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDRS = 27,
  parameter int unsigned REQID = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,

  input  logic             s0_arvalid,
  output logic             s0_arready,
  input  logic [ADDRS-1:0] s0_araddr,
  input  logic [REQID-1:0] s0_arid,
  input  logic [7:0]       s0_arlen,
  input  logic [1:0]       s0_arburst,
  output logic             s0_rvalid,
  input  logic             s0_rready,
  output logic             s0_rlast,
  output logic [1:0]       s0_rresp,
  output logic [REQID-1:0] s0_rid,
  output logic [WIDTH-1:0] s0_rdata,

  input  logic             s1_arvalid,
  output logic             s1_arready,
  input  logic [ADDRS-1:0] s1_araddr,
  input  logic [REQID-1:0] s1_arid,
  input  logic [7:0]       s1_arlen,
  input  logic [1:0]       s1_arburst,
  output logic             s1_rvalid,
  input  logic             s1_rready,
  output logic             s1_rlast,
  output logic [1:0]       s1_rresp,
  output logic [REQID-1:0] s1_rid,
  output logic [WIDTH-1:0] s1_rdata,

  output logic             m_arvalid,
  input  logic             m_arready,
  output logic [ADDRS-1:0] m_araddr,
  output logic [REQID-1:0] m_arid,
  output logic [7:0]       m_arlen,
  output logic [1:0]       m_arburst,
  input  logic             m_rvalid,
  output logic             m_rready,
  input  logic             m_rlast,
  input  logic [1:0]       m_rresp,
  input  logic [REQID-1:0] m_rid,
  input  logic [WIDTH-1:0] m_rdata,

  output logic [1:0]       grant_o
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [1:0] arb_gnt;
  logic       sel_s1;

  rr_arbiter2 u_rr_arbiter2 (
    .req_i  ({s1_arvalid, s0_arvalid}),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  assign sel_s1  = grant_q[1];
  assign grant_o = grant_q;

  // Payload paths are unconditional; they only matter while the matching valid is high.
  assign m_araddr  = sel_s1 ? s1_araddr  : s0_araddr;
  assign m_arid    = sel_s1 ? s1_arid    : s0_arid;
  assign m_arlen   = sel_s1 ? s1_arlen   : s0_arlen;
  assign m_arburst = sel_s1 ? s1_arburst : s0_arburst;

  assign s0_rlast = m_rlast;
  assign s0_rresp = m_rresp;
  assign s0_rid   = m_rid;
  assign s0_rdata = m_rdata;
  assign s1_rlast = m_rlast;
  assign s1_rresp = m_rresp;
  assign s1_rid   = m_rid;
  assign s1_rdata = m_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= GntNone;
      last_q  <= GntS1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    m_arvalid  = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s0_arvalid || s1_arvalid) begin
          grant_d = arb_gnt;
          state_d = StAddr;
        end
      end
      StAddr: begin
        m_arvalid  = sel_s1 ? s1_arvalid : s0_arvalid;
        s0_arready = grant_q[0] & m_arready;
        s1_arready = grant_q[1] & m_arready;
        if (m_arvalid && m_arready) begin
          state_d = StData;
        end
      end
      StData: begin
        // Straight wire from the owner's rready: stalls cost no extra cycle and nothing is held.
        m_rready  = sel_s1 ? s1_rready : s0_rready;
        s0_rvalid = grant_q[0] & m_rvalid;
        s1_rvalid = grant_q[1] & m_rvalid;
        if (m_rvalid && m_rready && m_rlast) begin
          state_d = StIdle;
          last_d  = grant_q;
          grant_d = GntNone;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = GntNone;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_ddr3_rd_arbiter.sv
// Randomized and directed bench for axi_ddr3_rd_arbiter against a transaction-level model.
module tb_axi_ddr3_rd_arbiter;
  import axi_arb_pkg::*;

  localparam int ADDRS = 27;
  localparam int REQID = 4;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [ADDRS-1:0] addr;
    logic [REQID-1:0] id;
    logic [7:0]       len;
    logic [1:0]       burst;
  } ar_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0]            s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [1:0][ADDRS-1:0] s_araddr;
  logic [1:0][REQID-1:0] s_arid, s_rid;
  logic [1:0][7:0]       s_arlen;
  logic [1:0][1:0]       s_arburst, s_rresp;
  logic [1:0][WIDTH-1:0] s_rdata;

  logic             m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [ADDRS-1:0] m_araddr;
  logic [REQID-1:0] m_arid, m_rid;
  logic [7:0]       m_arlen;
  logic [1:0]       m_arburst, m_rresp;
  logic [WIDTH-1:0] m_rdata;
  logic [1:0]       grant_o;

  always #5 clock = ~clock;

  axi_ddr3_rd_arbiter #(.ADDRS(ADDRS), .REQID(REQID), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]), .s0_araddr(s_araddr[0]),
    .s0_arid(s_arid[0]), .s0_arlen(s_arlen[0]), .s0_arburst(s_arburst[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]), .s0_rlast(s_rlast[0]),
    .s0_rresp(s_rresp[0]), .s0_rid(s_rid[0]), .s0_rdata(s_rdata[0]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]), .s1_araddr(s_araddr[1]),
    .s1_arid(s_arid[1]), .s1_arlen(s_arlen[1]), .s1_arburst(s_arburst[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]), .s1_rlast(s_rlast[1]),
    .s1_rresp(s_rresp[1]), .s1_rid(s_rid[1]), .s1_rdata(s_rdata[1]),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rlast(m_rlast), .m_rresp(m_rresp), .m_rid(m_rid), .m_rdata(m_rdata),
    .grant_o(grant_o)
  );

  // Transaction-level model: who owns the port, whether its AR is done, and queues of bursts.
  int  owner;
  bit  ar_done;
  int  last_port;
  ar_t pend_q[2][$];
  ar_t infl_q[2][$];
  bit  ctl_busy;
  ar_t ctl_ar;
  int  ctl_beat;
  bit  r_held;
  int  beats[2];
  int  rbeat[2];
  int  hs_cnt;
  int  addr_stall;
  int  gnt_log[$];
  int  rr_mode[2];
  int  arready_mode, arready_hold, rvalid_mode;
  int  total, bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] beat_data(input ar_t a, input int b);
    return WIDTH'(a.addr) * 3 + WIDTH'(b) * 32'h0101_0101 + WIDTH'(a.id);
  endfunction

  function automatic ar_t mk(input int addr, input int id, input int len);
    ar_t a;
    a.addr  = ADDRS'(addr);
    a.id    = REQID'(id);
    a.len   = 8'(len);
    a.burst = BURST_INCR;
    return a;
  endfunction

  function automatic int pick(input logic [1:0] req);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
`ifdef ARB_FIXED_PRIORITY_EN
    return 0;
`else
    return (last_port == 0) ? 1 : 0;
`endif
  endfunction

  function automatic bit busy();
    return owner >= 0 || pend_q[0].size() > 0 || pend_q[1].size() > 0 ||
           infl_q[0].size() > 0 || infl_q[1].size() > 0;
  endfunction

  task automatic reset_model();
    owner = -1; ar_done = 1'b0; last_port = 1;
    for (int p = 0; p < 2; p++) begin
      pend_q[p].delete(); infl_q[p].delete(); beats[p] = 0; rbeat[p] = 0;
    end
    ctl_busy = 1'b0; ctl_beat = 0; r_held = 1'b0;
    hs_cnt = 0; addr_stall = 0; gnt_log.delete(); arready_hold = 0;
    s_arvalid = '0; s_rready = '0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arburst = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = '0; m_rid = '0; m_rdata = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, grant_o, 2'b00);
    chk({tag, "_s_arready"}, s_arready, 2'b00);
    chk({tag, "_s_rvalid"}, s_rvalid, 2'b00);
    chk({tag, "_m_arvalid"}, m_arvalid, 1'b0);
    chk({tag, "_m_rready"}, m_rready, 1'b0);
  endtask

  task automatic drive_ar();
    for (int p = 0; p < 2; p++) begin
      if (pend_q[p].size() > 0) begin
        s_arvalid[p] = 1'b1;
        s_araddr[p]  = pend_q[p][0].addr;
        s_arid[p]    = pend_q[p][0].id;
        s_arlen[p]   = pend_q[p][0].len;
        s_arburst[p] = pend_q[p][0].burst;
      end else begin
        s_arvalid[p] = 1'b0;
        s_araddr[p]  = ADDRS'($urandom);
        s_arid[p]    = REQID'($urandom);
        s_arlen[p]   = 8'($urandom);
        s_arburst[p] = 2'($urandom);
      end
    end
  endtask

  task automatic drive();
    drive_ar();
    for (int p = 0; p < 2; p++) begin
      case (rr_mode[p])
        0:       s_rready[p] = 1'b1;
        1:       s_rready[p] = 1'($urandom_range(0, 1));
        default: s_rready[p] = ~s_rready[p];
      endcase
    end
    if (arready_hold > 0) begin
      m_arready = 1'b0;
      arready_hold--;
    end else begin
      m_arready = (arready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    if (ctl_busy) begin
      if (!r_held && (rvalid_mode == 0 || $urandom_range(0, 1) == 1)) begin
        m_rvalid = 1'b1;
        r_held   = 1'b1;
        m_rdata  = beat_data(ctl_ar, ctl_beat);
        m_rid    = ctl_ar.id;
        m_rlast  = (ctl_beat == int'(ctl_ar.len));
        m_rresp  = ($urandom_range(0, 3) == 0) ? 2'b10 : RESP_OKAY;
      end else if (!r_held) begin
        m_rvalid = 1'b0;
        m_rdata  = WIDTH'($urandom);
        m_rlast  = 1'($urandom);
      end
    end else begin
      m_rvalid = 1'b0;
      r_held   = 1'b0;
      m_rdata  = WIDTH'($urandom);
      m_rid    = REQID'($urandom);
      m_rlast  = 1'($urandom);
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then drive after the rising edge.
  task automatic step();
    logic [1:0] e_gnt, e_arr, e_rv;
    logic       e_marv, e_mrr;
    ar_t        a;
    @(negedge clock);
    e_gnt = (owner < 0) ? 2'b00 : 2'(1 << owner);
    e_arr = '0; e_rv = '0; e_marv = 1'b0; e_mrr = 1'b0;
    if (owner >= 0 && !ar_done) begin
      e_marv = s_arvalid[owner];
      e_arr[owner] = m_arready;
    end
    if (owner >= 0 && ar_done) begin
      e_mrr = s_rready[owner];
      e_rv[owner] = m_rvalid;
    end
    chk("grant_o", grant_o, e_gnt);
    chk("m_arvalid", m_arvalid, e_marv);
    chk("s_arready", s_arready, e_arr);
    chk("m_rready", m_rready, e_mrr);
    chk("s_rvalid", s_rvalid, e_rv);
    if (e_marv) begin
      a = pend_q[owner][0];
      chk("m_araddr", m_araddr, a.addr);
      chk("m_arid", m_arid, a.id);
      chk("m_arlen", m_arlen, a.len);
      chk("m_arburst", m_arburst, a.burst);
    end
    for (int p = 0; p < 2; p++) begin
      if (e_rv[p]) begin
        a = infl_q[p][0];
        chk("s_rdata", s_rdata[p], beat_data(a, rbeat[p]));
        chk("s_rid", s_rid[p], a.id);
        chk("s_rlast", s_rlast[p], rbeat[p] == int'(a.len));
        chk("s_rresp", s_rresp[p], m_rresp);
      end
    end

    if (owner < 0) begin
      if (s_arvalid != 2'b00) begin
        owner   = pick(s_arvalid);
        ar_done = 1'b0;
        gnt_log.push_back(1 << owner);
      end
    end else if (!ar_done) begin
      if (s_arvalid[owner] && m_arready) begin
        a = pend_q[owner].pop_front();
        infl_q[owner].push_back(a);
        ctl_ar = a; ctl_busy = 1'b1; ctl_beat = 0; r_held = 1'b0;
        hs_cnt++;
        ar_done = 1'b1;
      end else begin
        addr_stall++;
      end
    end else if (m_rvalid && s_rready[owner]) begin
      beats[owner]++;
      rbeat[owner]++;
      r_held = 1'b0;
      if (ctl_beat == int'(ctl_ar.len)) begin
        void'(infl_q[owner].pop_front());
        rbeat[owner] = 0;
        ctl_busy = 1'b0;
        last_port = owner;
        owner = -1;
      end else begin
        ctl_beat++;
      end
    end
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic run_done(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk({name, "_done"}, busy(), 1'b0);
  endtask

  // Reset asserted mid-cycle so its effect is seen before any clock edge.
  task automatic reset_pulse(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    chk_quiet(tag);
    reset_model();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_modes(input int rnd);
    rr_mode[0] = rnd; rr_mode[1] = rnd; arready_mode = rnd; rvalid_mode = rnd;
  endtask

  int exp_seq[8];

  initial begin
    int n;
    total = 0; bad = 0;
    reset_model();
    set_modes(0);
    reset_n = 1'b0;
    #3;
    chk_quiet("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // s0 alone, four beats
    pend_q[0].push_back(mk(0, 5, 3));
    drive_ar();
    run_done("s1", 100);
    chk("s1_hs", hs_cnt, 1);
    chk("s1_beats0", beats[0], 4);
    chk("s1_beats1", beats[1], 0);
    chk("s1_nlog", gnt_log.size(), 1);
    chk("s1_gnt0", gnt_log[0], 1);

    // simultaneous first requests after reset
    reset_pulse("r2");
    pend_q[0].push_back(mk('h100, 2, 7));
    pend_q[1].push_back(mk('h200, 9, 3));
    drive_ar();
    run_done("s2", 200);
    chk("s2_gnt0", gnt_log[0], 1);
    chk("s2_gnt1", gnt_log[1], 2);
    chk("s2_beats0", beats[0], 8);
    chk("s2_beats1", beats[1], 4);

    // four back-to-back pairs with random handshake timing
    reset_pulse("r3");
    set_modes(1);
    for (int i = 0; i < 4; i++) begin
      pend_q[0].push_back(mk('h1000 + i * 64, i, $urandom_range(0, 3)));
      pend_q[1].push_back(mk('h2000 + i * 64, 8 + i, $urandom_range(0, 3)));
    end
    drive_ar();
    run_done("s3", 2000);
`ifdef ARB_FIXED_PRIORITY_EN
    exp_seq = '{1, 1, 1, 1, 2, 2, 2, 2};
`else
    exp_seq = '{1, 2, 1, 2, 1, 2, 1, 2};
`endif
    chk("s3_nlog", gnt_log.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("s3_gnt%0d", i), gnt_log[i], exp_seq[i]);

    // s1 rready toggling every cycle
    reset_pulse("r4");
    set_modes(0);
    rr_mode[1] = 2;
    pend_q[1].push_back(mk('h3000, 3, 7));
    drive_ar();
    run_done("s4", 200);
    chk("s4_beats1", beats[1], 8);
    chk("s4_beats0", beats[0], 0);

    // reset mid-burst, then a fresh request
    reset_pulse("r5");
    set_modes(0);
    pend_q[0].push_back(mk('h4000, 1, 7));
    drive_ar();
    n = 0;
    while (beats[0] < 2 && n < 100) begin
      step();
      n++;
    end
    chk("s5_beat2", beats[0], 2);
    chk("s5_midburst", grant_o, 2'b01);
    reset_pulse("s5_reset");
    pend_q[0].push_back(mk('h5000, 6, 2));
    drive_ar();
    run_done("s5", 100);
    chk("s5_hs", hs_cnt, 1);
    chk("s5_beats0", beats[0], 3);
    chk("s5_gnt0", gnt_log[0], 1);

    // single beat on s1 behind a 5-cycle AR stall
    reset_pulse("r6");
    set_modes(0);
    arready_hold = 5;
    pend_q[1].push_back(mk('h6000, 'hA, 0));
    drive_ar();
    run_done("s6", 100);
    chk("s6_addr_stall", addr_stall, 5);
    chk("s6_hs", hs_cnt, 1);
    chk("s6_beats1", beats[1], 1);
    chk("s6_gnt0", gnt_log[0], 2);

    // random traffic on both ports
    reset_pulse("r7");
    set_modes(1);
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        rr_mode[0] = $urandom_range(0, 2);
        rr_mode[1] = $urandom_range(0, 2);
        arready_mode = $urandom_range(0, 1);
        rvalid_mode = $urandom_range(0, 1);
      end
      for (int p = 0; p < 2; p++) begin
        if (pend_q[p].size() < 2 && $urandom_range(0, 3) == 0)
          pend_q[p].push_back(mk($urandom, $urandom, $urandom_range(0, 7)));
      end
      drive_ar();
      step();
    end
    run_done("rand", 2000);
    chk("rand_hs", hs_cnt, gnt_log.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
